// File: rtl/cbus_sram_ctrl.sv
// cbus_sram_ctrl: CBus slave that turns single and burst transactions into 64-bit single-port SRAM accesses.
// Optional address window check with a sticky err flag: define CBUS_SRAM_RANGE_CHECK_EN.
package cbus_pkg;
    typedef enum logic {
        BURST_FIXED = 1'b0,
        BURST_INCR  = 1'b1
    } cbus_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        cbus_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

// state | meaning
// IDLE  | waiting for creq.valid; request latched on accept, nothing issued
// READ  | one SRAM read per cycle; each beat returned the following cycle
// WRITE | one SRAM write per cycle the master presents a beat
// DONE  | one quiet cycle so the master can drop valid
module cbus_sram_ctrl
    import cbus_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  cbus_req_t             creq,
    output cbus_resp_t            cresp,
    output logic                  sram_en,
    output logic [7:0]            sram_we,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [63:0]           sram_wdata,
    input  logic [63:0]           sram_rdata,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [4:0]            left_q, left_d;
    logic                  incr_q, incr_d;
    logic                  bad_q, bad_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_last_q, rd_last_d;

    logic                  below;
    logic [63:0]           offset;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_bad;
    logic                  unused_ok;

    // The extra top bit is the borrow, i.e. addr < BASE_ADDR.
    assign {below, offset} = {1'b0, creq.addr} - {1'b0, BASE_ADDR};
    assign req_idx         = offset[DEPTH_LOG2+2:3];
    assign unused_ok       = ^{creq.size, offset, below};

`ifdef CBUS_SRAM_RANGE_CHECK_EN
    logic err_q;

    assign req_bad = below || (offset[63:DEPTH_LOG2+3] != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && creq.valid && req_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign req_bad = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            incr_q    <= 1'b0;
            bad_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            incr_q    <= incr_d;
            bad_q     <= bad_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        incr_d     = incr_q;
        bad_d      = bad_q;
        rd_vld_d   = 1'b0;
        rd_last_d  = 1'b0;
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        cresp      = '0;

        case (state_q)
            IDLE: begin
                if (creq.valid) begin
                    addr_d  = req_idx;
                    left_d  = {1'b0, creq.len} + 5'd1;
                    incr_d  = (creq.burst == BURST_INCR);
                    bad_d   = req_bad;
                    state_d = creq.is_write ? WRITE : READ;
                end
            end
            READ: begin
                // left_q counts beats still to issue; the response side trails by one cycle.
                cresp.ready = rd_vld_q;
                cresp.last  = rd_last_q;
                if (rd_vld_q && !bad_q) begin
                    cresp.data = sram_rdata;
                end
                if (rd_last_q) begin
                    state_d = DONE;
                end else if (!creq.valid) begin
                    state_d = IDLE;
                end else if (left_q != 5'd0) begin
                    sram_en   = !bad_q;
                    sram_addr = bad_q ? '0 : addr_q;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (left_q == 5'd1);
                    left_d    = left_q - 5'd1;
                    if (incr_q) begin
                        addr_d = addr_q + DEPTH_LOG2'(1);
                    end
                end
            end
            WRITE: begin
                if (creq.valid) begin
                    cresp.ready = 1'b1;
                    cresp.last  = (left_q == 5'd1);
                    if (!bad_q) begin
                        sram_en    = 1'b1;
                        sram_we    = creq.strobe;
                        sram_addr  = addr_q;
                        sram_wdata = creq.data;
                    end
                    left_d = left_q - 5'd1;
                    if (incr_q) begin
                        addr_d = addr_q + DEPTH_LOG2'(1);
                    end
                    if (left_q == 5'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_sram_ctrl.sv
// Self-checking bench for cbus_sram_ctrl: per-cycle expectations are scheduled from transaction-level
// timing rules and a reference memory, then compared against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_cbus_sram_ctrl;
    import cbus_pkg::*;

    localparam int          D     = 4;
    localparam int          WORDS = 16;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          MAXC  = 8192;
`ifdef CBUS_SRAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    cbus_req_t    creq;
    cbus_resp_t   cresp;
    logic         sram_en;
    logic [7:0]   sram_we;
    logic [D-1:0] sram_addr;
    logic [63:0]  sram_wdata;
    logic [63:0]  sram_rdata;
    logic         err;

    cbus_sram_ctrl #(.DEPTH_LOG2(D), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .creq(creq), .cresp(cresp),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: 1-cycle read latency, garbage on rdata whenever no read was issued.
    logic [63:0] mem [WORDS];
    bit          pl_en = 1'b0;
    int          pl_idx = 0;
    logic [63:0] pl_val = '0;
    always @(posedge clk) begin
        sram_rdata <= {$urandom, $urandom};
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (sram_en) begin
            if (sram_we == 8'h00) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    logic [63:0] ref_mem [WORDS];

    bit        exp_ready [MAXC];
    bit        exp_last  [MAXC];
    bit [63:0] exp_data  [MAXC];
    bit        exp_en    [MAXC];
    bit [7:0]  exp_we    [MAXC];
    int        exp_addr  [MAXC];
    bit [63:0] exp_wdata [MAXC];
    bit        exp_err   [MAXC];
    bit        loose     [MAXC];

    bit        got_ready [MAXC];
    bit        got_last  [MAXC];
    bit [63:0] got_data  [MAXC];
    bit        got_en    [MAXC];
    int        got_addr  [MAXC];
    bit        got_err   [MAXC];

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && cyc < MAXC) begin
            got_ready[cyc] = cresp.ready;
            got_last[cyc]  = cresp.last;
            got_data[cyc]  = cresp.data;
            got_en[cyc]    = sram_en;
            got_addr[cyc]  = int'(sram_addr);
            got_err[cyc]   = err;
            chk("ready", cyc, 64'(cresp.ready), 64'(exp_ready[cyc]));
            chk("last",  cyc, 64'(cresp.last),  64'(exp_last[cyc]));
            chk("data",  cyc, cresp.data,       exp_data[cyc]);
            chk("en",    cyc, 64'(sram_en),     64'(exp_en[cyc]));
            chk("err",   cyc, 64'(err),         64'(exp_err[cyc]));
            if (exp_en[cyc] || !loose[cyc]) begin
                chk("we",   cyc, 64'(sram_we),   64'(exp_we[cyc]));
                chk("addr", cyc, 64'(sram_addr), 64'(exp_addr[cyc]));
            end
            if ((exp_en[cyc] && exp_we[cyc] != 8'h00) || !loose[cyc])
                chk("wdata", cyc, sram_wdata, exp_wdata[cyc]);
        end
    end

    function automatic bit is_bad(input logic [63:0] a);
        return RANGE_EN && ((a < BASE) || ((a - BASE) >= 64'(8 * WORDS)));
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return int'((off / 64'd8) % 64'(WORDS));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        creq.is_write = 1'($urandom);
        creq.size     = 3'($urandom);
        creq.addr     = {$urandom, $urandom};
        creq.strobe   = 8'($urandom);
        creq.data     = {$urandom, $urandom};
        creq.len      = 4'($urandom);
        creq.burst    = cbus_burst_t'(1'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            junk();
            creq.valid = 1'b0;
        end
    endtask

    task automatic preload(input int i, input logic [63:0] v);
        pl_en  = 1'b1;
        pl_idx = i;
        pl_val = v;
        ref_mem[i] = v;
        step();
        pl_en = 1'b0;
    endtask

    task automatic mark_err(input int a);
        for (int c = a + 1; c < MAXC; c++) exp_err[c] = 1'b1;
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_ready[c] = 0; exp_last[c] = 0; exp_data[c] = 0; exp_en[c] = 0;
            exp_we[c] = 0; exp_addr[c] = 0; exp_wdata[c] = 0; exp_err[c] = 0; loose[c] = 0;
        end
    endtask

    // abort_rel > 0: valid dropped in cycle accept+abort_rel; rst_rel > 0: reset in cycle accept+rst_rel.
    task automatic do_read(input logic [63:0] addr, input int n, input bit incr,
                           input int abort_rel, input int rst_rel, output int acc);
        int a, kmax, endc, w;
        bit bad;
        step();
        a = cyc;
        acc = a;
        junk();
        creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = addr;
        creq.len = 4'(n - 1); creq.burst = incr ? BURST_INCR : BURST_FIXED;
        bad = is_bad(addr);
        if (bad) mark_err(a);
        kmax = (abort_rel > 0) ? abort_rel - 1 : n;
        w = idx_of(addr);
        for (int k = 0; k < kmax; k++) begin
            exp_en[a+1+k]    = !bad;
            exp_addr[a+1+k]  = w;
            exp_ready[a+2+k] = 1'b1;
            exp_data[a+2+k]  = bad ? 64'h0 : ref_mem[w];
            if (incr) w = (w + 1) % WORDS;
        end
        if (kmax == n) exp_last[a+1+n] = 1'b1;
        endc = (abort_rel > 0) ? a + abort_rel : a + 1 + n;
        for (int c = a + 1; c <= endc; c++) loose[c] = 1'b1;
        for (int c = a + 1; c <= endc; c++) begin
            step();
            junk();
            creq.valid = !(abort_rel > 0 && c == endc);
            if (rst_rel > 0 && c == a + rst_rel) begin
                reset = 1'b0;
                clear_from(c + 1);
                step();
                reset = 1'b1;
                creq.valid = 1'b0;
                return;
            end
        end
        if (abort_rel == 0) begin
            step();
            junk();
            creq.valid = 1'($urandom);
        end
    endtask

    // stall >= 0: that many valid-low cycles after the first beat; stall < 0: random stalls.
    // fixed: beat k carries fdata+k with strobe fstrb.
    task automatic do_write(input logic [63:0] addr, input int n, input bit incr, input int stall,
                            input bit fixed, input logic [63:0] fdata, input logic [7:0] fstrb,
                            output int acc);
        int a, w, k, c, stalled;
        bit bad, v;
        step();
        a = cyc;
        acc = a;
        junk();
        creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = addr;
        creq.len = 4'(n - 1); creq.burst = incr ? BURST_INCR : BURST_FIXED;
        bad = is_bad(addr);
        if (bad) mark_err(a);
        w = idx_of(addr);
        k = 0;
        stalled = 0;
        while (k < n) begin
            step();
            junk();
            c = cyc;
            loose[c] = 1'b1;
            if (stall < 0) v = ($urandom_range(0, 3) != 0);
            else           v = !(k == 1 && stalled < stall);
            creq.valid = v;
            if (v) begin
                if (fixed) begin
                    creq.data   = fdata + 64'(k);
                    creq.strobe = fstrb;
                end
                exp_ready[c] = 1'b1;
                exp_last[c]  = (k == n - 1);
                if (!bad) begin
                    exp_en[c]    = 1'b1;
                    exp_we[c]    = creq.strobe;
                    exp_addr[c]  = w;
                    exp_wdata[c] = creq.data;
                    for (int b = 0; b < 8; b++)
                        if (creq.strobe[b]) ref_mem[w][8*b +: 8] = creq.data[8*b +: 8];
                end
                k++;
                if (incr) w = (w + 1) % WORDS;
            end else begin
                stalled++;
            end
        end
        step();
        junk();
        creq.valid = 1'($urandom);
    endtask

    initial begin
        int a, a2, n, r, cnt;
        logic [63:0] addr;
        reset = 1'b0;
        creq  = '0;
        step();
        cmp_on = 1'b1;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < WORDS; i++) preload(i, {$urandom, $urandom});
        chk("pin_reset_ready", 2, 64'(got_ready[2]), 64'h0);

        // single read of word 5
        preload(5, 64'hDEAD_BEEF_0123_4567);
        do_read(BASE + 64'h28, 1, 1'b1, 0, 0, a);
        idle(1);
        chk("pin_single_ready", a + 2, 64'(got_ready[a+2]), 64'h1);
        chk("pin_single_last",  a + 2, 64'(got_last[a+2]),  64'h1);
        chk("pin_single_data",  a + 2, got_data[a+2], 64'hDEAD_BEEF_0123_4567);
        chk("pin_single_done",  a + 3, 64'(got_ready[a+3]), 64'h0);

        // 16-beat INCR read
        for (int i = 0; i < WORDS; i++) preload(i, 64'(i * 'h11));
        do_read(BASE, 16, 1'b1, 0, 0, a);
        idle(1);
        chk("pin_incr_first", a + 2,  got_data[a+2],  64'h00);
        chk("pin_incr_final", a + 17, got_data[a+17], 64'hFF);
        chk("pin_incr_last",  a + 17, 64'(got_last[a+17]), 64'h1);
        chk("pin_incr_nolast", a + 16, 64'(got_last[a+16]), 64'h0);

        // strobed write then readback
        preload(3, 64'hFFFF_FFFF_FFFF_FFFF);
        do_write(BASE + 64'h18, 1, 1'b1, 0, 1'b1, 64'h0, 8'h0F, a);
        do_read(BASE + 64'h18, 1, 1'b1, 0, 0, a2);
        idle(1);
        chk("pin_wr_ready", a + 1, 64'(got_ready[a+1]), 64'h1);
        chk("pin_wr_last",  a + 1, 64'(got_last[a+1]),  64'h1);
        chk("pin_strobe_data", a2 + 2, got_data[a2+2], 64'hFFFF_FFFF_0000_0000);

        // 4-beat write with a two-cycle master stall after the first beat
        do_write(BASE + 64'h40, 4, 1'b1, 2, 1'b0, 64'h0, 8'h0, a);
        idle(1);
        cnt = 0;
        for (int c = a + 1; c <= a + 6; c++) cnt += int'(got_en[c]);
        chk("pin_stall_ready", a + 2, 64'(got_ready[a+2]), 64'h0);
        chk("pin_stall_writes", a, 64'(cnt), 64'd4);
        chk("pin_stall_last", a + 6, 64'(got_last[a+6]), 64'h1);

        // INCR wrap and FIXED write
        preload(15, 64'h5A5A_5A5A_5A5A_5A5A);
        do_read(BASE + 64'd112, 4, 1'b1, 0, 0, a);
        do_write(BASE + 64'd112, 4, 1'b0, 0, 1'b1, 64'h1234_0000_0000_0000, 8'hFF, a2);
        idle(2);
        chk("pin_wrap_addr2", a + 3, 64'(got_addr[a+3]), 64'd0);
        chk("pin_wrap_addr3", a + 4, 64'(got_addr[a+4]), 64'd1);
        chk("pin_fixed_word14", a2, mem[14], 64'h1234_0000_0000_0003);
        chk("pin_fixed_word15", a2, mem[15], 64'h5A5A_5A5A_5A5A_5A5A);

        // reset during the third beat of an 8-beat read, then a normal read
        do_read(BASE, 8, 1'b1, 0, 4, a);
        do_read(BASE + 64'h10, 2, 1'b1, 0, 0, a2);
        idle(1);
        chk("pin_rst_ready", a + 5, 64'(got_ready[a+5]), 64'h0);
        chk("pin_rst_en",    a + 5, 64'(got_en[a+5]),    64'h0);

        // read just past the window
        preload(0, 64'hC0FF_EE00_1111_2222);
        do_read(BASE + 64'(8 * WORDS), 1, 1'b1, 0, 0, a);
        idle(1);
`ifdef CBUS_SRAM_RANGE_CHECK_EN
        chk("pin_range_data", a + 2, got_data[a+2], 64'h0);
        chk("pin_range_err",  a + 3, 64'(got_err[a+3]), 64'h1);
`else
        chk("pin_alias_data", a + 2, got_data[a+2], 64'hC0FF_EE00_1111_2222);
        chk("pin_alias_err",  a + 3, 64'(got_err[a+3]), 64'h0);
`endif

        // abort of a read by dropping valid
        do_read(BASE, 8, 1'b1, 3, 0, a);
        idle(1);

        for (int t = 0; t < 150 && cyc < MAXC - 200; t++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       addr = BASE + 64'(8 * WORDS) + 64'($urandom_range(0, 500));
            else if (r < 14) addr = BASE - 64'($urandom_range(1, 500));
            else             addr = BASE + 64'($urandom_range(0, 8 * WORDS - 1));
            n = $urandom_range(1, 16);
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    do_read(addr, n, $urandom_range(0, 9) < 7, $urandom_range(1, n), 0, a);
                else
                    do_read(addr, n, $urandom_range(0, 9) < 7, 0, 0, a);
            end else begin
                do_write(addr, n, $urandom_range(0, 9) < 7, -1, 1'b0, 64'h0, 8'h0, a);
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        for (int i = 0; i < WORDS; i++) chk("mem_final", i, mem[i], ref_mem[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_sram_ctrl.md
Name: cbus_sram_ctrl

Overview:
- CBus slave that sits directly downstream of the top-level CBus output (`oreq`/`oresp`) and consumes the arbitrated I/D cache traffic.
- Converts single and burst CBus transactions into accesses on one synchronous single-port SRAM with 64-bit words and 1-cycle read latency.
- Serves as the memory endpoint for simulation and for FPGA on-chip RAM builds.

Parameters:
- DEPTH_LOG2, 16, log2 of SRAM depth in 64-bit words (default 512 KiB).
- BASE_ADDR, 64'h0, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset; 0 = reset
- creq  in  cbus_req_t  request from the CBus master (valid, is_write, size, addr, strobe, data, len, burst)
- cresp  out  cbus_resp_t  response (ready, last, data)
- sram_en  out  1  SRAM access enable
- sram_we  out  8  byte write enables (0 = read)
- sram_addr  out  DEPTH_LOG2  SRAM word index
- sram_wdata  out  64  write data
- sram_rdata  in  64  read data, valid the cycle after an enabled read
- err  out  1  sticky address-range error (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE; all outputs are 0 the following cycle.
  - Any burst in flight is abandoned and no further SRAM access is issued.
- Word index = ((addr - BASE_ADDR) >> 3) truncated to DEPTH_LOG2 bits.
- size is ignored; byte selection comes from strobe only.
- Beat count N = len + 1 (len encodes MLEN1..MLEN16 as 0..15).
- Beat address:
  - INCR: base + k, wrapping modulo 2^DEPTH_LOG2.
  - FIXED: base for every beat.
- States IDLE, READ, WRITE, DONE:
  - IDLE:
    - On creq.valid, latch addr, len, burst and is_write; clear beat counter k.
    - Go to WRITE if is_write, else READ. Nothing is issued in the accept cycle.
  - READ:
    - Issue sram_en=1, sram_we=0 for beat k each cycle while k<N.
    - The cycle after each issue, drive cresp.ready=1 and cresp.data=sram_rdata, registered.
    - Beat k is ready at accept+2+k; one beat per cycle with no bubbles.
    - cresp.last=1 with the beat N-1, then go to DONE.
  - WRITE:
    - Each cycle with creq.valid=1, drive sram_en=1, sram_we=creq.strobe, sram_wdata=creq.data.
    - cresp.ready=1 combinationally in the same cycle; beat k is written at accept+1+k.
    - cresp.last=1 with beat N-1, then go to DONE.
    - If creq.valid=0, ready=0, no write, k holds.
  - DONE: one cycle with all outputs 0 and creq ignored, so the master can drop valid. Then go to IDLE.
- Abort: creq.valid=0 during READ stops issuing and returns to IDLE next cycle, with no ready/last after the abort cycle (protocol-violation safety).
- cresp.last is never asserted without cresp.ready.
- cresp.data = 0 whenever ready=0.
- Back-to-back transactions have a minimum gap of accept → last → DONE → IDLE accept.

Optional Feature:
- Macro: CBUS_SRAM_RANGE_CHECK_EN.
- With the macro defined:
  - A request whose addr < BASE_ADDR, or whose addr - BASE_ADDR ≥ 8·2^DEPTH_LOG2, is flagged at accept.
  - Flagged reads still return N beats with data=0 and normal timing, with no SRAM enable.
  - Flagged writes return ready per beat with sram_en=0.
  - err is set to 1 and stays set until reset.
  - Burst-internal wrap is not checked.
- Without the macro: no check; addresses alias modulo depth; err is tied to 0.

Test Plan:
- Single read: preload word 5 = 64'hDEAD_BEEF_0123_4567; read, addr=BASE+0x28, len=MLEN1 → ready=1 and last=1 at accept+2 with that data, then DONE, then IDLE.
- INCR 16-beat read: preload words 0..15 = i·0x11, addr=BASE, len=MLEN16 → 16 consecutive ready cycles at accept+2..accept+17, data 0x00,0x11,…,0xFF; last only on the 16th.
- Strobed write then read: word 3 = all-ones; write data 64'h0, strobe 8'h0F → ready+last at accept+1; readback = 64'hFFFF_FFFF_0000_0000.
- Write with master stall: 4-beat INCR write, creq.valid low for 2 cycles after beat 1 → ready low during the stall; all 4 words written exactly once; last on beat 4.
- Wrap and FIXED: DEPTH_LOG2=4, INCR 4-beat read at word 14 → words 14,15,0,1. FIXED 4-beat write → only word 14 written, with the final beat's data.
- Reset mid-burst: reset=0 during beat 3 of an 8-beat read → next cycle ready=0, sram_en=0, state IDLE; a following request is served normally. With CBUS_SRAM_RANGE_CHECK_EN, read at BASE+8·2^DEPTH_LOG2 → data 0, err=1 and held.
